// File: rtl/ram_ctrl_pkg.sv
// Shared types and default sizes for the dual-requester RAM controller.
//   ctrl_state_e : controller FSM states (init sweep, serving requests)
//   req_id_e     : requester identity, used for arbitration and response steering
package ram_ctrl_pkg;

  localparam int unsigned DefAddrW = 4;
  localparam int unsigned DefDataW = 8;

  typedef enum logic {
    StInit,
    StServe
  } ctrl_state_e;

  typedef enum logic {
    ReqA,
    ReqB
  } req_id_e;

endpackage

// File: rtl/ram_array_16x8.sv
// Single-port synchronous RAM with read-old-data behaviour.
// Ports:
//   clk   : clock
//   en    : access enable; rdata register loads only on enabled cycles
//   we    : write enable (qualified by en)
//   addr  : word address
//   wdata : write data
//   rdata : registered read data, contents of addr before any same-cycle write
// The array has no reset; contents are established by the controller's init sweep.
module ram_array_16x8
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [Depth];
  logic [DATA_W-1:0] rdata_q;

  // Read is sampled from the pre-write contents, so a write returns the old word.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata_q <= mem[addr];
      if (we) begin
        mem[addr] <= wdata;
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between requesters A and B.
// After reset it writes INIT_VAL to every word (one word per cycle), then serves
// requests with round-robin arbitration. Each accepted access produces a one-cycle
// response pulse to its owner on the following cycle.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   a_valid/a_we/a_addr/a_wdata : requester A request
//   a_ready                     : A accepted this cycle (combinational)
//   a_rsp_valid/a_rsp_rdata     : A response pulse and data (data holds between pulses)
//   b_*                         : same for requester B
//   init_done                   : high once the init sweep has finished
module ram_port_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W   = DefAddrW,
  parameter int unsigned       DATA_W   = DefDataW,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              a_valid,
  output logic              a_ready,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_rsp_valid,
  output logic [DATA_W-1:0] a_rsp_rdata,

  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_rsp_valid,
  output logic [DATA_W-1:0] b_rsp_rdata,

  output logic              init_done
);

  ctrl_state_e       state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  req_id_e           last_grant_q, last_grant_d;

  logic              rsp_valid_q;
  req_id_e           rsp_owner_q;
  logic [DATA_W-1:0] a_hold_q, b_hold_q;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // Next-state, arbitration and RAM port mux.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    a_ready      = 1'b0;
    b_ready      = 1'b0;
    ram_en       = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = cnt_q;
    ram_wdata    = INIT_VAL;

    case (state_q)
      StInit: begin
        ram_en = 1'b1;
        ram_we = 1'b1;
        cnt_d  = cnt_q + ADDR_W'(1);
        if (&cnt_q) begin
          state_d = StServe;
        end
      end

      StServe: begin
        // On a tie the requester that did not win last time is granted.
        a_ready = a_valid & (~b_valid | (last_grant_q == ReqB));
        b_ready = b_valid & (~a_valid | (last_grant_q == ReqA));
        if (a_ready) begin
          ram_en       = 1'b1;
          ram_we       = a_we;
          ram_addr     = a_addr;
          ram_wdata    = a_wdata;
          last_grant_d = ReqA;
        end else if (b_ready) begin
          ram_en       = 1'b1;
          ram_we       = b_we;
          ram_addr     = b_addr;
          ram_wdata    = b_wdata;
          last_grant_d = ReqB;
        end
      end

      default: begin
        state_d = StInit;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StInit;
      cnt_q        <= '0;
      last_grant_q <= ReqB;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Response pipeline: owner/valid registered alongside the RAM read register.
  // Reset drops any in-flight response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_owner_q <= ReqA;
      a_hold_q    <= '0;
      b_hold_q    <= '0;
    end else begin
      rsp_valid_q <= a_ready | b_ready;
      if (a_ready | b_ready) begin
        rsp_owner_q <= b_ready ? ReqB : ReqA;
      end
      // Capture delivered data so each port holds its last response.
      if (a_rsp_valid) begin
        a_hold_q <= ram_rdata;
      end
      if (b_rsp_valid) begin
        b_hold_q <= ram_rdata;
      end
    end
  end

  assign a_rsp_valid = rsp_valid_q & (rsp_owner_q == ReqA);
  assign b_rsp_valid = rsp_valid_q & (rsp_owner_q == ReqB);
  assign a_rsp_rdata = a_rsp_valid ? ram_rdata : a_hold_q;
  assign b_rsp_rdata = b_rsp_valid ? ram_rdata : b_hold_q;
  assign init_done   = (state_q == StServe);

  ram_array_16x8 #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: a negedge monitor models arbitration and
// memory contents, pushes expected responses on each modelled accept and pops them
// when the DUT pulses a response.
module tb_ram_port_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_valid, a_ready, a_we, a_rsp_valid;
  logic [3:0] a_addr;
  logic [7:0] a_wdata, a_rsp_rdata;
  logic       b_valid, b_ready, b_we, b_rsp_valid;
  logic [3:0] b_addr;
  logic [7:0] b_wdata, b_rsp_rdata;
  logic       init_done;

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .ADDR_W   (4),
    .DATA_W   (8),
    .INIT_VAL (8'h00)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a_valid     (a_valid),
    .a_ready     (a_ready),
    .a_we        (a_we),
    .a_addr      (a_addr),
    .a_wdata     (a_wdata),
    .a_rsp_valid (a_rsp_valid),
    .a_rsp_rdata (a_rsp_rdata),
    .b_valid     (b_valid),
    .b_ready     (b_ready),
    .b_we        (b_we),
    .b_addr      (b_addr),
    .b_wdata     (b_wdata),
    .b_rsp_valid (b_rsp_valid),
    .b_rsp_rdata (b_rsp_rdata),
    .init_done   (init_done)
  );

  typedef struct packed {
    logic        owner;  // 0 = A, 1 = B
    logic [7:0]  data;
    logic [31:0] cyc;
  } exp_t;

  exp_t        sb[$];
  logic        glog[$];
  logic [7:0]  model [16];
  logic        last_g;
  logic [7:0]  last_a, last_b;
  logic [31:0] cyc;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic reset_model();
    sb.delete();
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    last_g = 1'b1;
    last_a = 8'h00;
    last_b = 8'h00;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_init_done"}, init_done, 0);
    check_eq({tag, "_a_ready"}, a_ready, 0);
    check_eq({tag, "_b_ready"}, b_ready, 0);
    check_eq({tag, "_a_rsp_valid"}, a_rsp_valid, 0);
    check_eq({tag, "_b_rsp_valid"}, b_rsp_valid, 0);
    check_eq({tag, "_a_rsp_rdata"}, a_rsp_rdata, 0);
    check_eq({tag, "_b_rsp_rdata"}, b_rsp_rdata, 0);
  endtask

  // Cycle index since reset release; cycle 0 is the first cycle with rst_n high.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  logic       m_serve, m_ea, m_eb, m_we;
  logic [3:0] m_ad;
  logic [7:0] m_wd;
  exp_t       m_e;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      m_serve = (cyc >= 16);
      check_eq("init_done", init_done, m_serve);
      m_ea = m_serve & a_valid & (~b_valid | last_g);
      m_eb = m_serve & b_valid & (~a_valid | ~last_g);
      check_eq("a_ready", a_ready, m_ea);
      check_eq("b_ready", b_ready, m_eb);

      if (a_rsp_valid | b_rsp_valid) begin
        check_eq("rsp_onehot", a_rsp_valid & b_rsp_valid, 0);
        if (sb.size() == 0) begin
          check_eq("rsp_unexpected", {a_rsp_valid, b_rsp_valid}, 0);
        end else begin
          m_e = sb.pop_front();
          check_eq("rsp_owner", {a_rsp_valid, b_rsp_valid}, m_e.owner ? 2'b01 : 2'b10);
          check_eq("rsp_latency", cyc - m_e.cyc, 1);
          if (m_e.owner) begin
            check_eq("b_rsp_rdata", b_rsp_rdata, m_e.data);
            last_b = m_e.data;
          end else begin
            check_eq("a_rsp_rdata", a_rsp_rdata, m_e.data);
            last_a = m_e.data;
          end
        end
      end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
        check_eq("rsp_missing", a_rsp_valid | b_rsp_valid, 1);
        void'(sb.pop_front());
      end

      if (!a_rsp_valid) check_eq("a_rsp_hold", a_rsp_rdata, last_a);
      if (!b_rsp_valid) check_eq("b_rsp_hold", b_rsp_rdata, last_b);

      if (m_ea | m_eb) begin
        m_ad      = m_eb ? b_addr  : a_addr;
        m_we      = m_eb ? b_we    : a_we;
        m_wd      = m_eb ? b_wdata : a_wdata;
        m_e.owner = m_eb;
        m_e.data  = model[m_ad];
        m_e.cyc   = cyc;
        if (m_we) model[m_ad] = m_wd;
        sb.push_back(m_e);
        last_g = m_eb;
      end

      if (a_ready & a_valid)      glog.push_back(1'b0);
      else if (b_ready & b_valid) glog.push_back(1'b1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic who, input logic we, input logic [3:0] addr,
                     input logic [7:0] data);
    if (!who) begin
      a_valid = 1'b1; a_we = we; a_addr = addr; a_wdata = data;
    end else begin
      b_valid = 1'b1; b_we = we; b_addr = addr; b_wdata = data;
    end
    step();
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    a_valid = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_valid = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    rst_n = 1'b0;
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");

    // A requests from cycle 0; must wait out the init sweep and be taken at cycle 16.
    rst_n   = 1'b1;
    a_valid = 1'b1; a_we = 1'b0; a_addr = 4'd0;
    repeat (17) step();
    a_valid = 1'b0;

    for (int i = 0; i < 16; i++) req(1'b0, 1'b0, i[3:0], 8'h00);
    step();

    req(1'b0, 1'b1, 4'd3, 8'hA5);
    req(1'b1, 1'b0, 4'd3, 8'h00);
    step();

    // Continuous contention; last grant was B so A should lead.
    glog.delete();
    a_valid = 1'b1; b_valid = 1'b1; a_we = 1'b0; b_we = 1'b0;
    for (int k = 0; k < 6; k++) begin
      a_addr = 4'(k);
      b_addr = 4'(k + 8);
      step();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    check_eq("grant_count", glog.size(), 6);
    for (int k = 0; k < glog.size() && k < 6; k++)
      check_eq($sformatf("grant%0d", k), glog[k], k % 2);
    step();

    req(1'b0, 1'b1, 4'd15, 8'h3C);
    req(1'b0, 1'b0, 4'd15, 8'h00);
    step();

    // Reset lands in the same cycle a read of addr 7 is accepted.
    req(1'b0, 1'b1, 4'd7, 8'hFF);
    req(1'b0, 1'b0, 4'd7, 8'h00);
    step();
    a_valid = 1'b1; a_we = 1'b0; a_addr = 4'd7;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    reset_model();
    #1;
    check_reset_outputs("mid");
    a_valid = 1'b0;
    @(posedge clk);
    #1;
    check_eq("mid_no_rsp", a_rsp_valid, 0);
    step();
    rst_n = 1'b1;
    begin
      int n = 0;
      while (init_done !== 1'b1 && n < 40) begin
        step();
        n++;
      end
    end
    check_eq("reinit_done", init_done, 1);
    req(1'b0, 1'b0, 4'd7, 8'h00);
    step();
    step();
    check_eq("sb_drain", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
